// File: rtl/counter_wrap_tracker_if.sv
// rtl/counter_wrap_tracker_if.sv - observation bus between a mod-12 counter and its wrap tracker
interface counter_wrap_tracker_if #(
    parameter int WRAP_W = 8
);
    logic              mode;
    logic              load;
    logic [3:0]        data_in;
    logic [3:0]        data_out;
    logic              carry;
    logic              borrow;
    logic [WRAP_W-1:0] wrap_count;
    logic              err_range;
    logic              err_step;
    logic [7:0]        err_cnt;

    modport master (
        output mode, load, data_in, data_out,
        input  carry, borrow, wrap_count, err_range, err_step, err_cnt
    );

    modport slave (
        input  mode, load, data_in, data_out,
        output carry, borrow, wrap_count, err_range, err_step, err_cnt
    );
endinterface

// File: rtl/counter_wrap_tracker.sv
// rtl/counter_wrap_tracker.sv - mod-12 counter wrap/epoch tracker; error checks under WRAP_TRACKER_ERR_EN
module counter_wrap_tracker #(
    parameter int WRAP_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    counter_wrap_tracker_if.slave  bus
);
    typedef enum logic {INIT, TRACK} state_t;

    state_t            state;
    logic              prev_mode;
    logic              prev_load;
    logic [3:0]        prev_data_in;
    logic [3:0]        prev_data_out;
    logic              carry_q;
    logic              borrow_q;
    logic [WRAP_W-1:0] wrap_q;
    logic [3:0]        expected;
    logic              step_chk;
    logic              carry_hit;
    logic              borrow_hit;
    logic              unused_prev_data_in;

    // The load value is kept as part of the sample but no rule consumes it.
    assign unused_prev_data_in = ^prev_data_in;

    always_comb begin
        expected = 4'd0;
        if (prev_mode)
            expected = (prev_data_out == 4'd11) ? 4'd0 : prev_data_out + 4'd1;
        else
            expected = (prev_data_out == 4'd0) ? 4'd11 : prev_data_out - 4'd1;
    end

    // Loads and out-of-range previous samples carry no step expectation.
    assign step_chk   = (state == TRACK) && !prev_load && (prev_data_out <= 4'd11);
    assign carry_hit  = step_chk &&  prev_mode && (prev_data_out == 4'd11) && (bus.data_out == 4'd0);
    assign borrow_hit = step_chk && !prev_mode && (prev_data_out == 4'd0)  && (bus.data_out == 4'd11);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= INIT;
            prev_mode     <= 1'b0;
            prev_load     <= 1'b0;
            prev_data_in  <= 4'd0;
            prev_data_out <= 4'd0;
            carry_q       <= 1'b0;
            borrow_q      <= 1'b0;
            wrap_q        <= '0;
        end else begin
            state         <= TRACK;
            prev_mode     <= bus.mode;
            prev_load     <= bus.load;
            prev_data_in  <= bus.data_in;
            prev_data_out <= bus.data_out;
            carry_q       <= carry_hit;
            borrow_q      <= borrow_hit;
            if (carry_hit)
                wrap_q <= wrap_q + WRAP_W'(1);
            else if (borrow_hit)
                wrap_q <= wrap_q - WRAP_W'(1);
        end
    end

    assign bus.carry      = carry_q;
    assign bus.borrow     = borrow_q;
    assign bus.wrap_count = wrap_q;

`ifdef WRAP_TRACKER_ERR_EN
    logic       err_range_q;
    logic       err_step_q;
    logic [7:0] err_cnt_q;
    logic       range_hit;
    logic       step_hit;

    assign range_hit = (state == TRACK) && (bus.data_out > 4'd11);
    assign step_hit  = step_chk && (bus.data_out != expected);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_range_q <= 1'b0;
            err_step_q  <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            if (range_hit)
                err_range_q <= 1'b1;
            if (step_hit)
                err_step_q <= 1'b1;
            if ((range_hit || step_hit) && (err_cnt_q != 8'hFF))
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_range = err_range_q;
    assign bus.err_step  = err_step_q;
    assign bus.err_cnt   = err_cnt_q;
`else
    assign bus.err_range = 1'b0;
    assign bus.err_step  = 1'b0;
    assign bus.err_cnt   = 8'd0;
`endif
endmodule

// File: tb/tb_counter_wrap_tracker.sv
// tb/tb_counter_wrap_tracker.sv - scoreboard bench for counter_wrap_tracker
module tb_counter_wrap_tracker;
`ifdef WRAP_TRACKER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic       carry;
        logic       borrow;
        logic [7:0] wrap;
        logic       er;
        logic       es;
        logic [7:0] ec;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    counter_wrap_tracker_if #(.WRAP_W(8)) bus ();
    counter_wrap_tracker #(.WRAP_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    obs_t exp_q[$];
    obs_t got_q[$];
    int   errors = 0;
    int   checks = 0;

    bit         m_track;
    int         m_pm, m_pl, m_pd;
    logic [7:0] m_wrap, m_ec;
    bit         m_er, m_es, m_carry, m_borrow;

    task automatic drive(input bit r, input bit md, input bit ld, input int din, input int dout);
        obs_t e;
        obs_t o;
        bit   err;
        int   nxt;
        rst = r; bus.mode = md; bus.load = ld;
        bus.data_in = 4'(din); bus.data_out = 4'(dout);
        if (r) begin
            m_track = 0; m_pm = 0; m_pl = 0; m_pd = 0;
            m_wrap = 0; m_ec = 0; m_er = 0; m_es = 0; m_carry = 0; m_borrow = 0;
        end else begin
            m_carry = 0; m_borrow = 0; err = 0;
            if (m_track) begin
                if (dout > 11) begin m_er = 1; err = 1; end
                if (m_pl == 0 && m_pd <= 11) begin
                    nxt = (m_pm != 0) ? (m_pd + 1) % 12 : (m_pd + 11) % 12;
                    if (dout != nxt) begin m_es = 1; err = 1; end
                    if (m_pm != 0 && m_pd == 11 && dout == 0) begin m_carry = 1; m_wrap = m_wrap + 8'd1; end
                    if (m_pm == 0 && m_pd == 0 && dout == 11) begin m_borrow = 1; m_wrap = m_wrap - 8'd1; end
                end
                if (err && m_ec != 8'd255) m_ec = m_ec + 8'd1;
            end
            m_pm = md; m_pl = ld; m_pd = dout; m_track = 1;
        end
        e.carry = m_carry; e.borrow = m_borrow; e.wrap = m_wrap;
        e.er = ERR_EN & m_er; e.es = ERR_EN & m_es; e.ec = ERR_EN ? m_ec : 8'd0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.carry = bus.carry; o.borrow = bus.borrow; o.wrap = bus.wrap_count;
        o.er = bus.err_range; o.es = bus.err_step; o.ec = bus.err_cnt;
        got_q.push_back(o);
    endtask

    task automatic test_reset();
        obs_t e, o;
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 1, 9, 14);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = got_q.pop_front(); checks++;
            if (o !== e || o !== '0) begin
                errors++;
                $display("FAIL reset: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_up_wrap();
        obs_t e, o;
        int   carries = 0;
        drive(1, 0, 0, 0, 0);
        for (int v = 0; v <= 11; v++) drive(0, 1, 0, 0, v);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = got_q.pop_front(); checks++;
            carries += int'(o.carry);
            if (o !== e) begin errors++; $display("FAIL up_wrap: got %h want %h", o, e); end
        end
        checks++;
        if (carries != 1 || bus.wrap_count !== 8'd1 || bus.err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL up_wrap_total: carries=%0d wrap=%0d ec=%0d want 1/1/0", carries, bus.wrap_count, bus.err_cnt);
        end
    endtask

    task automatic test_down_wrap();
        obs_t e, o;
        int   borrows = 0;
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 11);
        drive(0, 0, 0, 0, 10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = got_q.pop_front(); checks++;
            borrows += int'(o.borrow);
            if (o !== e) begin errors++; $display("FAIL down_wrap: got %h want %h", o, e); end
        end
        checks++;
        if (borrows != 1 || bus.wrap_count !== 8'hFF || bus.err_step !== 1'b0) begin
            errors++;
            $display("FAIL down_wrap_total: borrows=%0d wrap=%h es=%b want 1/ff/0", borrows, bus.wrap_count, bus.err_step);
        end
    endtask

    task automatic test_load();
        obs_t e, o;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 10);
        drive(0, 1, 1, 5, 11);
        drive(0, 1, 0, 0, 5);
        drive(0, 1, 0, 0, 6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = got_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL load: got %h want %h", o, e); end
        end
        checks++;
        if (bus.carry !== 1'b0 || bus.wrap_count !== 8'd0 || bus.err_step !== 1'b0) begin
            errors++;
            $display("FAIL load_total: carry=%b wrap=%0d es=%b want 0/0/0", bus.carry, bus.wrap_count, bus.err_step);
        end
    endtask

    task automatic test_errors();
        obs_t e, o;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 2);
        drive(0, 1, 0, 0, 3);
        drive(0, 1, 0, 0, 7);
        drive(0, 1, 0, 0, 13);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = got_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL errors: got %h want %h", o, e); end
        end
        checks++;
        if (bus.err_step !== ERR_EN || bus.err_range !== ERR_EN || bus.err_cnt !== (ERR_EN ? 8'd2 : 8'd0)) begin
            errors++;
            $display("FAIL errors_total: es=%b er=%b ec=%0d", bus.err_step, bus.err_range, bus.err_cnt);
        end
        for (int i = 0; i < 260; i++) drive(0, 1, 0, 0, 15);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = got_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL err_saturate: got %h want %h", o, e); end
        end
        checks++;
        if (bus.err_cnt !== (ERR_EN ? 8'd255 : 8'd0)) begin
            errors++;
            $display("FAIL err_cnt_sat: got %0d", bus.err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 10);
        drive(0, 1, 0, 0, 11);
        drive(1, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 5);
        drive(0, 1, 0, 0, 6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = got_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset_mid: got %h want %h", o, e); end
        end
        checks++;
        if (bus.carry !== 1'b0 || bus.wrap_count !== 8'd0 || bus.err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_total: carry=%b wrap=%0d ec=%0d want 0/0/0", bus.carry, bus.wrap_count, bus.err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 11);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 11);
        drive(0, 0, 0, 0, 10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = got_q.pop_front(); checks++;
            if (o !== e || (o.carry && o.borrow)) begin
                errors++;
                $display("FAIL back_to_back: got %h want %h", o, e);
            end
        end
        checks++;
        if (bus.wrap_count !== 8'd0 || bus.err_step !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_total: wrap=%0d es=%b want 0/0", bus.wrap_count, bus.err_step);
        end
    endtask

    initial begin
        bus.mode = 0; bus.load = 0; bus.data_in = 0; bus.data_out = 0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter_wrap_tracker.md
COUNTER_WRAP_TRACKER -- requirements
Module: counter_wrap_tracker

Interface
REQ-001 The block SHALL have parameter WRAP_W, default 8, width of the wrap epoch counter.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset, same signal that resets the mod-12 counter.
REQ-004 The block SHALL have port mode  input  1  counter direction as driven to the counter (1 = up, 0 = down).
REQ-005 The block SHALL have port load  input  1  counter load strobe as driven to the counter.
REQ-006 The block SHALL have port data_in  input  4  counter load value.
REQ-007 The block SHALL have port data_out  input  4  current counter output, consumed by this block.
REQ-008 The block SHALL have port carry  output  1  one-cycle pulse on an up wrap 11->0.
REQ-009 The block SHALL have port borrow  output  1  one-cycle pulse on a down wrap 0->11.
REQ-010 The block SHALL have port wrap_count  output  WRAP_W  signed-free modular epoch count: +1 per carry, -1 per borrow.
REQ-011 The block SHALL have port err_range  output  1  sticky flag: data_out > 11 seen.
REQ-012 The block SHALL have port err_step  output  1  sticky flag: illegal transition seen.
REQ-013 The block SHALL have port err_cnt  output  8  count of error cycles, saturating at 255.

Function
REQ-014 The block SHALL register each cycle a sample {mode, load, data_in, data_out} as prev_*.
REQ-015 The block SHALL implement FSM states INIT and TRACK; INIT after reset, INIT->TRACK unconditionally on the first non-reset cycle; no checks or pulses in INIT.
REQ-016 In TRACK, when prev_load = 0, expected value SHALL be: prev_mode=1: prev_data_out==11 ? 0 : prev_data_out+1; prev_mode=0: prev_data_out==0 ? 11 : prev_data_out-1.
REQ-017 In TRACK, when prev_load = 1, no step check SHALL be applied and neither carry nor borrow SHALL fire that cycle.
REQ-018 carry SHALL assert in the cycle after the cycle that sampled prev_load=0, prev_mode=1, prev_data_out=11, when data_out=0 is observed.
REQ-019 borrow SHALL assert in the cycle after the cycle that sampled prev_load=0, prev_mode=0, prev_data_out=0, when data_out=11 is observed.
REQ-020 carry and borrow SHALL be registered outputs, 1-cycle latency after the observing edge, and SHALL never be high simultaneously.
REQ-021 wrap_count SHALL update on the same edge as the carry/borrow pulse, wrapping modulo 2^WRAP_W in both directions (0-1 -> all ones).
REQ-022 err_range SHALL set when data_out > 11 in TRACK, regardless of load; a prev_data_out > 11 SHALL suppress the step check for the following cycle.
REQ-023 err_step SHALL set when prev_load=0, prev_data_out <= 11 and data_out != expected.
REQ-024 err_cnt SHALL increment by one per cycle in which err_range or err_step condition is true (one increment even if both), saturating at 255.
REQ-025 Error flags SHALL be sticky until reset.

Reset
REQ-026 On rst=1 at posedge clk: FSM SHALL go to INIT; carry, borrow, err_range, err_step SHALL be 0; wrap_count and err_cnt SHALL be 0; prev_* SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard any pending pulse; the first cycle after reset SHALL produce no pulse or error.

Configuration
REQ-028 Macro WRAP_TRACKER_ERR_EN defined: error checking (REQ-022..REQ-025) SHALL be compiled in.
REQ-029 Macro WRAP_TRACKER_ERR_EN undefined: err_range, err_step, err_cnt SHALL be constant 0; carry/borrow/wrap_count behaviour unchanged.

Verification
REQ-030 Up count 0..11..0 with mode=1, load=0 -> one carry pulse after 11->0, wrap_count=1, no errors.
REQ-031 Down count 0->11 with mode=0, load=0, wrap_count=0 -> one borrow pulse, wrap_count=8'hFF, no errors.
REQ-032 load=1 with data_in=5 while data_out=11, mode=1 -> no carry, no err_step; next up step 5->6 checked clean.
REQ-033 Inject data_out 3->7 with mode=1, load=0 -> err_step=1, err_cnt=1; inject data_out=13 -> err_range=1, err_cnt=2.
REQ-034 rst pulsed the cycle 11->0 is observed -> no carry, all outputs 0, INIT then TRACK.
REQ-035 Build without WRAP_TRACKER_ERR_EN, repeat REQ-033 stimulus -> err outputs stay 0.
